// File: rtl/pix_stream_pkg.sv
// Shared types and constants for the raster pixel stream source.
// Build option: PIX_STREAM_GAP_EN enables the inter-row gap state in the top.
package pix_stream_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 20;
  localparam int DIM_W_DEF     = 16;
  // RAM read strobe to out_valid: one cycle of RAM latency plus the output register.
  localparam int RD_PIPE_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/pix_stream_src_raster_addr_gen.sv
// Raster position generator: row/col/linear address counters for one frame.
// The address is a running counter, so no row*width multiply is needed.
// Build option: none (PIX_STREAM_GAP_EN only affects the top).
module raster_addr_gen
  import pix_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic              eol,
  output logic              last,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col,
  output logic [ADDR_W-1:0] addr
);

  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Flags describe the position currently being read.
  assign eol  = (col_q == (width - DIM_W'(1)));
  assign last = eol && (row_q == (height - DIM_W'(1)));

  assign row  = row_q;
  assign col  = col_q;
  assign addr = addr_q;

  // Next position: clear wins over step; col wraps at the row end.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clear) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (step) begin
      addr_d = addr_q + ADDR_W'(1);
      if (eol) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/pix_stream_src.sv
// Raster-order pixel stream source: reads a WxH frame from a synchronous
// image RAM and emits it as a valid/pixel stream with row and frame markers.
// Build option: PIX_STREAM_GAP_EN adds gap_cycles and the GAP state, which
// inserts idle cycles between rows.
module pix_stream_src
  import pix_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pixel,
  output logic              out_eol,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef PIX_STREAM_GAP_EN
  ,
  input  logic [7:0]        gap_cycles
`endif
);

  state_e state_q, state_d;

  logic [DIM_W-1:0] w_q, h_q;
  logic             latch_dims;

  logic              gen_clear, gen_step;
  logic              gen_eol, gen_last;
  logic [DIM_W-1:0]  gen_row, gen_col;
  logic [ADDR_W-1:0] gen_addr;

  logic rd_en;
  logic done_q, done_d;

  logic [RD_PIPE_DEPTH-1:0] vld_sr_q;
  logic [RD_PIPE_DEPTH-1:0] eol_sr_q;
  logic [RD_PIPE_DEPTH-1:0] last_sr_q;
  logic [DATA_W-1:0]        pix_p2;

`ifdef PIX_STREAM_GAP_EN
  logic [7:0] gap_q, gap_d;
`endif

  raster_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (gen_clear),
    .step   (gen_step),
    .width  (w_q),
    .height (h_q),
    .eol    (gen_eol),
    .last   (gen_last),
    .row    (gen_row),
    .col    (gen_col),
    .addr   (gen_addr)
  );

  // Row/col are only observability outputs of the generator; flags carry what we need.
  logic unused_pos;
  assign unused_pos = ^{gen_row, gen_col};

  // FSM next state, read issue and counter control.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    gen_clear  = 1'b0;
    gen_step   = 1'b0;
    latch_dims = 1'b0;
    rd_en      = 1'b0;
`ifdef PIX_STREAM_GAP_EN
    gap_d      = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch_dims = 1'b1;
          gen_clear  = 1'b1;
          // An empty frame completes immediately without touching the RAM.
          if ((img_width == '0) || (img_height == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!pause) begin
          rd_en    = 1'b1;
          gen_step = 1'b1;
          if (gen_last) begin
            state_d = ST_DRAIN;
`ifdef PIX_STREAM_GAP_EN
          end else if (gen_eol && (gap_cycles != 8'd0)) begin
            state_d = ST_GAP;
            gap_d   = gap_cycles;
`endif
          end
        end
      end
`ifdef PIX_STREAM_GAP_EN
      ST_GAP: begin
        // Counts every cycle regardless of pause, so the gap length is fixed.
        if (gap_q <= 8'd1) begin
          state_d = ST_RUN;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
`endif
      ST_DRAIN: begin
        // The frame's last pixel on the output means nothing is left in flight.
        if (last_sr_q[RD_PIPE_DEPTH-1]) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and read-tracking shift registers; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      vld_sr_q  <= '0;
      eol_sr_q  <= '0;
      last_sr_q <= '0;
`ifdef PIX_STREAM_GAP_EN
      gap_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      // p0 -> p1: read issued, data returns from the RAM next cycle
      // p1 -> p2: RAM data captured into the output register
      vld_sr_q  <= {vld_sr_q[RD_PIPE_DEPTH-2:0], rd_en};
      eol_sr_q  <= {eol_sr_q[RD_PIPE_DEPTH-2:0], rd_en & gen_eol};
      last_sr_q <= {last_sr_q[RD_PIPE_DEPTH-2:0], rd_en & gen_last};
`ifdef PIX_STREAM_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end

  // Frame dimensions captured when a start is accepted.
  always_ff @(posedge clk) begin
    if (latch_dims) begin
      w_q <= img_width;
      h_q <= img_height;
    end
  end

  // Output pixel register; cleared on reset so the stream reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_p2 <= '0;
    end else if (vld_sr_q[RD_PIPE_DEPTH-2]) begin
      pix_p2 <= mem_rdata;
    end
  end

  assign mem_rd_en = rd_en;
  assign mem_addr  = gen_addr;
  assign out_valid = vld_sr_q[RD_PIPE_DEPTH-1];
  assign out_eol   = eol_sr_q[RD_PIPE_DEPTH-1];
  assign out_last  = last_sr_q[RD_PIPE_DEPTH-1];
  assign out_pixel = pix_p2;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_pix_stream_src.sv
// Scoreboard bench for pix_stream_src: the driver pushes expected pixels and
// done cycles, the negedge monitor pops and compares.
module tb_pix_stream_src;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pause;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic        mem_rd_en;
  logic [19:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        out_valid;
  logic [7:0]  out_pixel;
  logic        out_eol;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef PIX_STREAM_GAP_EN
  logic [7:0]  gap_cycles;
`endif

  pix_stream_src dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .img_width  (img_width),
    .img_height (img_height),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_eol    (out_eol),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
`ifdef PIX_STREAM_GAP_EN
    ,
    .gap_cycles (gap_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Image RAM with RAM[i] = i, one cycle read latency.
  logic [7:0] ram [0:255];
  initial for (int i = 0; i < 256; i++) ram[i] = 8'(i);
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr[7:0]];

  typedef struct packed {
    logic [7:0]  pix;
    logic        eol;
    logic        last;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pixel and done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("stray_valid", {24'd0, out_pixel}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", {24'd0, out_pixel}, {24'd0, e.pix});
        chk("markers", {30'd0, out_eol, out_last}, {30'd0, e.eol, e.last});
        chk("pixel_cycle", cyc, e.cyc);
      end
    end else if (out_eol || out_last) begin
      chk("marker_without_valid", {30'd0, out_eol, out_last}, 32'd0);
    end
    if (done) begin
      done_seen++;
      chk("busy_in_done_cycle", {31'd0, busy}, 32'd0);
      if (done_q.size() == 0) chk("stray_done", cyc, 32'hFFFF_FFFF);
      else                    chk("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    chk({tag, "_mem_addr"},  {12'd0, mem_addr},  32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_pixel"}, {24'd0, out_pixel}, 32'd0);
    chk({tag, "_out_eol"},   {31'd0, out_eol},   32'd0);
    chk({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_done"},      {31'd0, done},      32'd0);
  endtask

  // Back-to-back frame with an optional pause window [p_lo,p_hi] (cycles after
  // start) and an optional extra start pulse at cycle restart_k.
  task automatic run_frame(input int w, input int h, input int p_lo, input int p_hi,
                           input int restart_k);
    int n, k, idx, tgt;
    n   = cyc;
    idx = 0;
    k   = 1;
    while (idx < w * h) begin
      if (!(k >= p_lo && k <= p_hi)) begin
        exp_q.push_back('{pix: 8'(idx), eol: (idx % w == w - 1), last: (idx == w * h - 1),
                          cyc: 32'(n + k + 2)});
        idx++;
      end
      k++;
    end
    if (w * h > 0) done_q.push_back(n + (k - 1) + 3);
    else           done_q.push_back(n + 1);
    tgt        = done_seen + 1;
    img_width  = 16'(w);
    img_height = 16'(h);
    start      = 1'b1;
    tick();
    for (int kk = 1; kk < w * h + 60 && done_seen < tgt; kk++) begin
      pause = (kk >= p_lo && kk <= p_hi);
      start = (kk == restart_k);
      if (kk == 1) begin
        chk("first_busy",  {31'd0, busy},      {31'd0, (w * h > 0)});
        chk("first_rd_en", {31'd0, mem_rd_en}, {31'd0, (w * h > 0) && !pause});
        chk("first_addr",  {12'd0, mem_addr},  32'd0);
      end
      tick();
    end
    pause = 1'b0;
    start = 1'b0;
    chk("frame_done_seen", done_seen, tgt);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    pause      = 1'b0;
    img_width  = 16'd0;
    img_height = 16'd0;
`ifdef PIX_STREAM_GAP_EN
    gap_cycles = 8'd0;
`endif
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // 4x3 contiguous frame.
    run_frame(4, 3, 0, 0, 0);
    // 5x5 with pause over cycles N+4..N+6.
    run_frame(5, 5, 4, 6, 0);
    // Empty frame: done next cycle, no reads, busy stays low.
    run_frame(0, 7, 0, 0, 0);
    // 8x8 with a second start mid-frame that must be ignored.
    run_frame(8, 8, 0, 0, 20);

    // 6x6 frame interrupted by reset at the 10th read.
    begin
      int n, tgt;
      n = cyc;
      for (int i = 0; i < 8; i++)
        exp_q.push_back('{pix: 8'(i), eol: (i == 5), last: 1'b0, cyc: 32'(n + 3 + i)});
      img_width  = 16'd6;
      img_height = 16'd6;
      start      = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      chk("tenth_read_addr", {12'd0, mem_addr}, 32'd9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_all_zero("after_rst");
      tgt = done_seen;
      repeat (8) tick();
      chk("no_done_after_rst", done_seen, tgt);
      chk("rst_flush_queue", exp_q.size(), 32'd0);
      run_frame(6, 6, 0, 0, 0);
    end

`ifdef PIX_STREAM_GAP_EN
    // 3x3 with a 2-cycle gap after each non-final row.
    begin
      int n, tgt;
      int rk [9] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
      n = cyc;
      for (int i = 0; i < 9; i++)
        exp_q.push_back('{pix: 8'(i), eol: (i % 3 == 2), last: (i == 8),
                          cyc: 32'(n + rk[i] + 2)});
      done_q.push_back(n + 16);
      tgt        = done_seen + 1;
      gap_cycles = 8'd2;
      img_width  = 16'd3;
      img_height = 16'd3;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int kk = 1; kk < 40 && done_seen < tgt; kk++) begin
        chk("gap_rd_en", {31'd0, mem_rd_en},
            {31'd0, (kk inside {[1:3], [6:8], [11:13]})});
        tick();
      end
      chk("gap_done_seen", done_seen, tgt);
      gap_cycles = 8'd0;
      repeat (3) tick();
    end
`endif

    chk("exp_queue_empty", exp_q.size(), 32'd0);
    chk("done_queue_empty", done_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pix_stream_src.md
# pix_stream_src

Raster-order pixel stream transmitter that feeds the `conv_3x3` first-layer window pipeline. On a start pulse it reads a W×H 8-bit frame from a synchronous single-port image RAM, one read per cycle. It emits the frame as an `out_valid`/`out_pixel` stream with no backpressure, plus line and frame markers. It is the sending end of the stream interface the convolution engine consumes.

## Interface
- `DATA_W`, 8, pixel width
- `ADDR_W`, 20, image RAM address width
- `DIM_W`, 16, width/height field width; matches the conv `img_width` port

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle frame start; sampled only in IDLE
- `pause`  in  1  while high, no new RAM reads are issued
- `img_width`  in  DIM_W  pixels per row; sampled at start
- `img_height`  in  DIM_W  rows per frame; sampled at start
- `mem_rd_en`  out  1  RAM read strobe
- `mem_addr`  out  ADDR_W  RAM read address, row*width+col
- `mem_rdata`  in  DATA_W  RAM data, valid the cycle after `mem_rd_en`
- `out_valid`  out  1  pixel valid, to conv `in_valid`
- `out_pixel`  out  DATA_W  pixel, to conv `in_pixel`
- `out_eol`  out  1  qualifies the last pixel of a row
- `out_last`  out  1  qualifies the last pixel of the frame
- `busy`  out  1  high from the cycle after an accepted start until `done`
- `done`  out  1  one-cycle frame-complete pulse
- `gap_cycles`  in  8  idle cycles between rows; present only with `PIX_STREAM_GAP_EN`

## Operation
- FSM states: IDLE, RUN, GAP, DRAIN.
  - IDLE + start: latch W/H, clear row/col/addr, go to RUN.
  - If W==0 or H==0: no reads, `done` pulse in the next cycle, stay IDLE.
- RUN issues one read per cycle while `pause`=0. `mem_addr` is an incrementing counter; no multiplier.
  - col wraps at W-1 and row increments.
  - The read of (H-1, W-1) moves the FSM to DRAIN.
- GAP exists only with the macro (see Configuration).
- DRAIN waits for the in-flight reads to return, pulses `done`, and returns to IDLE.
- Read pipeline: a 2-stage valid/eol/last shift register tracks `mem_rd_en`. `out_pixel` is `mem_rdata` registered.
- `pause` never drops a pixel. Reads already issued still emit, so `out_valid` has holes that match the pause holes.
- start during busy is ignored. `pause` in IDLE or DRAIN has no effect.
- Address counter width is ADDR_W and wraps silently. Frames with W*H > 2^ADDR_W are out of contract.
- Reset in any state:
  - all outputs go to 0 and the FSM to IDLE in the next cycle;
  - the in-flight pipeline is flushed; no valid, `done` or marker is emitted after reset.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `out_valid`=0, `out_pixel`=0, `out_eol`=0, `out_last`=0, `busy`=0, `done`=0.
- start in cycle N (IDLE):
  - cycle N+1: `busy`=1, `mem_rd_en`=1, `mem_addr`=0.
  - cycle N+3: first `out_valid`.
- Read-to-output latency: 2 cycles.
- Unpaused frame:
  - reads in cycles N+1..N+W*H;
  - `out_valid` in cycles N+3..N+W*H+2, with `out_last` in the final one;
  - `done`=1 and `busy`=0 in cycle N+W*H+3.
- Next start is accepted in the cycle `done` is high.
- `out_eol` and `out_last` are asserted only together with `out_valid`.

## Configuration
- `PIX_STREAM_GAP_EN` defined:
  - adds the `gap_cycles` port and the GAP state;
  - after the last read of each row except the final row, exactly `gap_cycles` cycles pass with `mem_rd_en`=0;
  - `gap_cycles`=0 means no gap;
  - `pause` during GAP does not extend the gap count.
  - Used to exercise the conv line-buffer row handling under non-contiguous input.
- Not defined: no port and no GAP state; rows are back-to-back.

## Structure
- `pix_stream_pkg`: FSM state enum (IDLE, RUN, GAP, DRAIN), default DATA_W/ADDR_W/DIM_W constants, read-pipeline depth constant (2).
- One sub-module, `raster_addr_gen`, owns the row/col/addr counters and flags:
  - inputs: step, clear;
  - outputs: `eol`, `last`, row, col, addr.
- The top owns the FSM, gap counter and read pipeline.

## Test plan
- W=4, H=3, RAM[i]=i, no pause → 12 valids, values 0..11, in cycles N+3..N+14; `out_eol` on values 3, 7, 11; `out_last` on 11; `done` in N+15.
- W=5, H=5, `pause` high for cycles N+4..N+6 → values 0..24 in order with a 3-cycle hole in `out_valid`; `done` 3 cycles later than the unpaused case.
- W=0, H=7 → no `mem_rd_en`, no `out_valid`; `done` in N+1; `busy` stays 0.
- start pulsed again mid-frame (W=8, H=8) → ignored; exactly 64 pixels and a single `done`.
- `rst` asserted at the 10th read of a W=6, H=6 frame → from the next cycle all outputs are 0; no further `out_valid` or `done`; a new start then streams 0..35 correctly.
- `PIX_STREAM_GAP_EN`, W=3, H=3, `gap_cycles`=2 → reads in cycles N+1..3, N+6..8, N+11..13; `done` in N+16; output stream into `conv_3x3` gives the same results as the no-gap run.
